// File: rtl/rtc_pkg.sv
// rtc_pkg: shared calendar limits, display format encodings and month-length helpers.
package rtc_pkg;
    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [6:0] YEAR_MAX = 7'd99;
    localparam logic       FMT_24   = 1'b0;
    localparam logic       FMT_12   = 1'b1;

    // Years are 20YY within 2000..2099, so every fourth year is a leap year.
    function automatic logic is_leap(input logic [6:0] year);
        return year[1:0] == 2'b00;
    endfunction

    function automatic logic [4:0] mlen(input logic [3:0] month, input logic [6:0] year);
        return (month == 4'd2) ? (is_leap(year) ? 5'd29 : 5'd28) :
               (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
    endfunction
endpackage

// File: rtl/bin2bcd2.sv
// bin2bcd2: converts a binary value 0..99 into tens and ones BCD digits.
module bin2bcd2 (
    input  logic [6:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);
    assign o_tens = 4'(i_bin / 7'd10);
    assign o_ones = 4'(i_bin % 7'd10);
endmodule

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: one-second prescaler, time of day and calendar with validated loads,
// rollover pulses and registered BCD digits in 12/24 h display format.
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int CNT_W         = 7,
    parameter int RST_YEAR      = 16,
    parameter int RST_MONTH     = 11,
    parameter int RST_DAY       = 1
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       RUN,
    input  logic       TIME_FORMAT,
    input  logic       SET_TIME,
    input  logic       SET_DATE,
    input  logic [4:0] SET_HOUR,
    input  logic [5:0] SET_MIN,
    input  logic [5:0] SET_SEC,
    input  logic [6:0] SET_YEAR,
    input  logic [3:0] SET_MONTH,
    input  logic [4:0] SET_DAY,
    output logic [3:0] H10,
    output logic [3:0] H1,
    output logic [3:0] M10,
    output logic [3:0] M1,
    output logic [3:0] S10,
    output logic [3:0] S1,
    output logic [3:0] Y10,
    output logic [3:0] Y1,
    output logic [3:0] MT10,
    output logic [3:0] MT1,
    output logic [3:0] D10,
    output logic [3:0] D1,
    output logic       PM,
    output logic       SEC_TICK,
    output logic       DAY_ROLL,
    output logic       SET_ERR
);
    logic [CNT_W-1:0] r_presc;
    logic [5:0]       r_sec, r_min;
    logic [4:0]       r_hour, r_day;
    logic [3:0]       r_month;
    logic [6:0]       r_year;
    logic             r_sec_tick, r_day_roll, r_set_err, r_pm;
    logic [47:0]      r_digits;

    logic        w_tick, w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_carry, w_month_end;
    logic        w_time_ok, w_date_ok, w_time_ld, w_date_ld;
    logic [4:0]  w_hour_disp;
    logic [47:0] w_bcd;

    assign w_tick      = RUN && (r_presc == CNT_W'(TICKS_PER_SEC - 1));
    assign w_sec_wrap  = r_sec == SEC_MAX;
    assign w_min_wrap  = w_sec_wrap && (r_min == MIN_MAX);
    assign w_hour_wrap = w_min_wrap && (r_hour == HOUR_MAX);
    assign w_day_carry = w_tick && w_hour_wrap;
    assign w_month_end = r_day == mlen(r_month, r_year);

    assign w_time_ok = (SET_HOUR <= HOUR_MAX) && (SET_MIN <= MIN_MAX) && (SET_SEC <= SEC_MAX);
    assign w_date_ok = (SET_MONTH >= 4'd1) && (SET_MONTH <= 4'd12) && (SET_DAY >= 5'd1) &&
                       (SET_DAY <= mlen(SET_MONTH, SET_YEAR)) && (SET_YEAR <= YEAR_MAX);
    assign w_time_ld = SET_TIME && w_time_ok;
    assign w_date_ld = SET_DATE && w_date_ok;

    // Hour stays 24 h internally; only the displayed value is remapped.
    assign w_hour_disp = (TIME_FORMAT == FMT_24) ? r_hour :
                         (r_hour == 5'd0) ? 5'd12 :
                         (r_hour > 5'd12) ? r_hour - 5'd12 : r_hour;

    bin2bcd2 u_hour  (.i_bin({2'b00, w_hour_disp}), .o_tens(w_bcd[47:44]), .o_ones(w_bcd[43:40]));
    bin2bcd2 u_min   (.i_bin({1'b0, r_min}),        .o_tens(w_bcd[39:36]), .o_ones(w_bcd[35:32]));
    bin2bcd2 u_sec   (.i_bin({1'b0, r_sec}),        .o_tens(w_bcd[31:28]), .o_ones(w_bcd[27:24]));
    bin2bcd2 u_year  (.i_bin(r_year),               .o_tens(w_bcd[23:20]), .o_ones(w_bcd[19:16]));
    bin2bcd2 u_month (.i_bin({3'b000, r_month}),    .o_tens(w_bcd[15:12]), .o_ones(w_bcd[11:8]));
    bin2bcd2 u_day   (.i_bin({2'b00, r_day}),       .o_tens(w_bcd[7:4]),   .o_ones(w_bcd[3:0]));

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_presc    <= '0;
            r_sec      <= '0;
            r_min      <= '0;
            r_hour     <= '0;
            r_year     <= 7'(RST_YEAR);
            r_month    <= 4'(RST_MONTH);
            r_day      <= 5'(RST_DAY);
            r_sec_tick <= 1'b0;
            r_day_roll <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            r_set_err  <= (SET_TIME && !w_time_ok) || (SET_DATE && !w_date_ok);
            r_day_roll <= w_day_carry && !w_time_ld && !w_date_ld;
            if (w_time_ld) begin
                r_hour  <= SET_HOUR;
                r_min   <= SET_MIN;
                r_sec   <= SET_SEC;
                r_presc <= '0;
            end else if (RUN) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    r_sec <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
                    if (w_sec_wrap) r_min <= (r_min == MIN_MAX) ? 6'd0 : r_min + 6'd1;
                    if (w_min_wrap) r_hour <= (r_hour == HOUR_MAX) ? 5'd0 : r_hour + 5'd1;
                end
            end
            // A valid date load overrides the midnight advance on the same edge.
            if (w_date_ld) begin
                r_year  <= SET_YEAR;
                r_month <= SET_MONTH;
                r_day   <= SET_DAY;
            end else if (w_day_carry && !w_time_ld) begin
                r_day <= w_month_end ? 5'd1 : r_day + 5'd1;
                if (w_month_end) r_month <= (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
                if (w_month_end && r_month == 4'd12) r_year <= (r_year == YEAR_MAX) ? 7'd0 : r_year + 7'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        r_digits <= w_bcd;
        r_pm     <= r_hour >= 5'd12;
    end

    assign {H10, H1, M10, M1, S10, S1, Y10, Y1, MT10, MT1, D10, D1} = r_digits;
    assign PM       = r_pm;
    assign SEC_TICK = r_sec_tick;
    assign DAY_ROLL = r_day_roll;
    assign SET_ERR  = r_set_err;
endmodule

// File: tb/tb_rtc_calendar_core.sv
// tb_rtc_calendar_core: directed and randomized checks of the RTC core against a
// seconds-of-day / calendar-table reference model.
module tb_rtc_calendar_core;
    localparam int T = 4;

    logic       CLK = 0, RESETN = 0, RUN = 0, TIME_FORMAT = 0, SET_TIME = 0, SET_DATE = 0;
    logic [4:0] SET_HOUR = 0, SET_DAY = 1;
    logic [5:0] SET_MIN = 0, SET_SEC = 0;
    logic [6:0] SET_YEAR = 0;
    logic [3:0] SET_MONTH = 1;
    logic [3:0] H10, H1, M10, M1, S10, S1, Y10, Y1, MT10, MT1, D10, D1;
    logic       PM, SEC_TICK, DAY_ROLL, SET_ERR;

    rtc_calendar_core #(.TICKS_PER_SEC(T), .CNT_W(2), .RST_YEAR(16), .RST_MONTH(11), .RST_DAY(1)) dut (
        .CLK(CLK), .RESETN(RESETN), .RUN(RUN), .TIME_FORMAT(TIME_FORMAT),
        .SET_TIME(SET_TIME), .SET_DATE(SET_DATE), .SET_HOUR(SET_HOUR), .SET_MIN(SET_MIN),
        .SET_SEC(SET_SEC), .SET_YEAR(SET_YEAR), .SET_MONTH(SET_MONTH), .SET_DAY(SET_DAY),
        .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1),
        .Y10(Y10), .Y1(Y1), .MT10(MT10), .MT1(MT1), .D10(D10), .D1(D1),
        .PM(PM), .SEC_TICK(SEC_TICK), .DAY_ROLL(DAY_ROLL), .SET_ERR(SET_ERR)
    );

    always #5 CLK = ~CLK;

    logic [23:0] d_time, d_date;
    assign d_time = {H10, H1, M10, M1, S10, S1};
    assign d_date = {Y10, Y1, MT10, MT1, D10, D1};

    int          n_chk = 0, n_pass = 0;
    int          m_presc = 0, m_tod = 0, m_y = 0, m_mo = 1, m_d = 1;
    bit          m_known = 0, e_dig_ok = 0;
    logic [23:0] e_time = 0, e_date = 0;
    logic        e_pm = 0;
    logic [2:0]  e_flags = 0;

    function automatic int dim(int mo, int y);
        int t[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo < 1 || mo > 12) return 0;
        return (mo == 2 && y % 4 == 0) ? 29 : t[mo];
    endfunction

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(string name, logic [23:0] got, logic [23:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: time of day as a seconds count, calendar stepped through a month table.
    task automatic model_step();
        bit tick, carry, tok, dok;
        int h;
        tick = RUN && m_presc == T - 1;
        h = m_tod / 3600;
        e_dig_ok = m_known;
        e_time = {bcd(TIME_FORMAT ? ((h % 12 == 0) ? 12 : h % 12) : h), bcd((m_tod / 60) % 60), bcd(m_tod % 60)};
        e_date = {bcd(m_y), bcd(m_mo), bcd(m_d)};
        e_pm = h >= 12;
        if (!RESETN) begin
            m_presc = 0; m_tod = 0; m_y = 16; m_mo = 11; m_d = 1;
            e_flags = 3'b000;
            m_known = 1;
        end else begin
            tok = SET_HOUR <= 23 && SET_MIN <= 59 && SET_SEC <= 59;
            dok = SET_YEAR <= 99 && SET_DAY >= 1 && int'(SET_DAY) <= dim(int'(SET_MONTH), int'(SET_YEAR));
            carry = 0;
            if (SET_TIME && tok) begin
                m_tod = int'(SET_HOUR) * 3600 + int'(SET_MIN) * 60 + int'(SET_SEC);
                m_presc = 0;
            end else if (RUN) begin
                m_presc = (m_presc + 1) % T;
                if (tick) begin
                    m_tod = (m_tod + 1) % 86400;
                    carry = m_tod == 0;
                end
            end
            e_flags = {tick, 1'b0, (SET_TIME && !tok) || (SET_DATE && !dok)};
            if (SET_DATE && dok) begin
                m_y = int'(SET_YEAR); m_mo = int'(SET_MONTH); m_d = int'(SET_DAY);
            end else if (carry) begin
                e_flags[1] = 1'b1;
                m_d++;
                if (m_d > dim(m_mo, m_y)) begin
                    m_d = 1;
                    m_mo++;
                    if (m_mo > 12) begin
                        m_mo = 1;
                        m_y = (m_y + 1) % 100;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (m_known) check("flags", 24'({SEC_TICK, DAY_ROLL, SET_ERR}), 24'(e_flags));
        if (e_dig_ok) begin
            check("time", d_time, e_time);
            check("date", d_date, e_date);
            check("pm", 24'(PM), 24'(e_pm));
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load_time(int h, int m, int s);
        SET_HOUR = 5'(h); SET_MIN = 6'(m); SET_SEC = 6'(s); SET_TIME = 1;
        step();
        SET_TIME = 0;
    endtask

    task automatic load_date(int y, int mo, int d);
        SET_YEAR = 7'(y); SET_MONTH = 4'(mo); SET_DAY = 5'(d); SET_DATE = 1;
        step();
        SET_DATE = 0;
    endtask

    initial begin
        int cnt;
        RUN = 1;
        step(3);
        RESETN = 1;
        step();
        check("reset_time", d_time, 24'h000000);
        check("reset_date", d_date, 24'h161101);
        cnt = 0;
        repeat (39) begin step(); cnt += int'(SEC_TICK); end
        check("tick_count", 24'(cnt), 24'd10);
        step();
        check("ten_seconds", d_time, 24'h000010);

        load_date(16, 2, 28);
        load_time(23, 59, 58);
        cnt = 0;
        repeat (9) begin step(); cnt += int'(DAY_ROLL); end
        check("leap_time", d_time, 24'h000000);
        check("leap_date", d_date, 24'h160229);
        check("leap_rolls", 24'(cnt), 24'd1);

        load_date(17, 2, 28);
        load_time(23, 59, 58);
        step(9);
        check("nonleap_date", d_date, 24'h170301);

        load_date(99, 12, 31);
        load_time(23, 59, 59);
        step(5);
        check("ywrap_time", d_time, 24'h000000);
        check("ywrap_date", d_date, 24'h000101);

        RUN = 0;
        TIME_FORMAT = 1;
        load_time(0, 5, 0);
        step();
        check("h12_midnight", d_time, 24'h120500);
        check("h12_midnight_pm", 24'(PM), 24'd0);
        load_time(12, 0, 0);
        step();
        check("h12_noon", d_time, 24'h120000);
        check("h12_noon_pm", 24'(PM), 24'd1);
        load_time(13, 0, 0);
        step();
        check("h12_13", d_time, 24'h010000);
        TIME_FORMAT = 0;
        step();
        check("h24_13", d_time, 24'h130000);
        TIME_FORMAT = 1;
        step();
        check("h12_back", d_time, 24'h010000);

        TIME_FORMAT = 0;
        load_date(17, 2, 29);
        check("bad_date_err", 24'(SET_ERR), 24'd1);
        step();
        check("bad_date_kept", d_date, 24'h000101);
        load_time(24, 0, 0);
        check("bad_time_err", 24'(SET_ERR), 24'd1);
        step();
        check("bad_time_kept", d_time, 24'h130000);

        RUN = 1;
        load_time(1, 2, 3);
        step(3);
        load_time(10, 20, 30);
        step();
        check("collide_time", d_time, 24'h102030);

        step(2);
        RESETN = 0;
        step();
        RESETN = 1;
        step();
        check("midreset_time", d_time, 24'h000000);
        check("midreset_date", d_date, 24'h161101);
        step(2);
        check("presc_no_tick", 24'(SEC_TICK), 24'd0);
        step();
        check("presc_first_tick", 24'(SEC_TICK), 24'd1);

        for (int i = 0; i < 4000; i++) begin
            bit near;
            RUN = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 49) == 0) TIME_FORMAT = ~TIME_FORMAT;
            near = $urandom_range(0, 1) == 1;
            SET_TIME = $urandom_range(0, 39) == 0;
            SET_HOUR = near ? 5'd23 : 5'($urandom_range(0, 25));
            SET_MIN  = near ? 6'd59 : 6'($urandom_range(0, 61));
            SET_SEC  = near ? 6'($urandom_range(50, 59)) : 6'($urandom_range(0, 61));
            SET_DATE = $urandom_range(0, 39) == 0;
            SET_MONTH = 4'($urandom_range(0, 13));
            SET_DAY  = $urandom_range(0, 1) ? 5'($urandom_range(27, 31)) : 5'($urandom_range(0, 31));
            SET_YEAR = ($urandom_range(0, 3) == 0) ? 7'd99 : 7'($urandom_range(0, 101));
            RESETN = $urandom_range(0, 499) != 0;
            step();
        end
        SET_TIME = 0;
        SET_DATE = 0;
        RESETN = 1;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
Parametrised timekeeping core for the alarm clock. Divides CLK into one-second ticks and keeps sec/min/hour plus a day/month/year calendar. Month lengths and leap years are handled correctly. Offers 12/24 h display, validated time/date loading and rollover event pulses. It feeds the display mux and the alarm comparator with per-digit BCD values.

Parameters:
TICKS_PER_SEC, 100, CLK cycles per second; must be >= 2.
CNT_W, 7, prescaler width; must satisfy 2**CNT_W >= TICKS_PER_SEC.
RST_YEAR, 16, reset year, 0..99, meaning 20YY.
RST_MONTH, 11, reset month, 1..12.
RST_DAY, 1, reset day, 1..31; must be valid for RST_MONTH/RST_YEAR.

Ports:
CLK  in  1  clock
RESETN  in  1  synchronous active-low reset
RUN  in  1  1 = time advances; 0 = frozen (prescaler also holds)
TIME_FORMAT  in  1  0 = 24 h display, 1 = 12 h display
SET_TIME  in  1  one-cycle strobe: load SET_HOUR/SET_MIN/SET_SEC
SET_DATE  in  1  one-cycle strobe: load SET_YEAR/SET_MONTH/SET_DAY
SET_HOUR  in  5  0..23, always 24 h encoding
SET_MIN  in  6  0..59
SET_SEC  in  6  0..59
SET_YEAR  in  7  0..99
SET_MONTH  in  4  1..12
SET_DAY  in  5  1..month length
H10,H1,M10,M1,S10,S1  out  4 each  BCD time digits, in display format
Y10,Y1,MT10,MT1,D10,D1  out  4 each  BCD date digits
PM  out  1  1 when hour >= 12 (valid in both formats)
SEC_TICK  out  1  one-cycle pulse on each second increment
DAY_ROLL  out  1  one-cycle pulse when the date advances
SET_ERR  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (RESETN=0 at a CLK edge) sets: prescaler=0, hour=min=sec=0, date=RST_YEAR/RST_MONTH/RST_DAY, and SEC_TICK=DAY_ROLL=SET_ERR=0. Digits reflect the reset state one cycle later. Reset mid-load discards the load.
- Prescaler counts 0..TICKS_PER_SEC-1 while RUN=1. tick = (prescaler==TICKS_PER_SEC-1) & RUN.
- On tick:
  - sec increments; 59 wraps to 0 and carries to min.
  - min 59 wraps to 0 and carries to hour.
  - hour 23 wraps to 0 and carries to day.
  - All carries resolve in the same edge; there is no ripple latency.
- Day carry:
  - if day == mlen(month, year): day=1 and month increments;
  - otherwise day+1;
  - month 12 wraps to 1 and year increments;
  - year 99 wraps to 0.
- mlen: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; for Feb, 29 if year[1:0]==0, else 28.
- SEC_TICK is registered and asserts the cycle after the tick edge. DAY_ROLL does the same on the day-carry edge.
- Hour is stored internally in 24 h form only. TIME_FORMAT affects display only; switching it never alters stored time.
  - 12 h display mapping: 0→12, 1..12→same, 13..23→hour-12.
- Digit outputs are registered: 1-cycle latency from the state change.
- SET_TIME validation: hour<=23, min<=59, sec<=59.
  - Valid: load all three and clear the prescaler.
  - Invalid: no state change, SET_ERR pulses.
- SET_DATE validation: month 1..12, day 1..mlen(SET_MONTH, SET_YEAR), year<=99.
  - Valid: load all three.
  - Invalid: no change, SET_ERR pulses.
- Simultaneous events:
  - A set strobe on a tick edge wins for the fields it loads. SET_TIME suppresses that tick's carry into the date.
  - SET_DATE on a day-carry edge loads the SET values; no further increment is applied, and DAY_ROLL is suppressed.
  - SET_TIME and SET_DATE together: each is validated independently and each valid one applies. SET_ERR pulses if either is invalid.
- RUN=0 with a set strobe: the load still applies.

Decomposition:
- Shared package rtc_pkg holds:
  - month-length function mlen(month, year);
  - leap-year function;
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, YEAR_MAX=99;
  - format encodings FMT_24=0, FMT_12=1.
- One sub-module, bin2bcd2: 7-bit binary 0..99 to two 4-bit BCD digits, purely combinational. Instantiated 6×.

Test Plan:
- Tick rate: TICKS_PER_SEC=4, RUN=1, run 40 cycles → exactly 10 SEC_TICK pulses, S10/S1 = 1/0.
- Time rollover: SET_TIME 23:59:58, date 16-02-28 → after 2 ticks, time 00:00:00, date 16-02-29, one DAY_ROLL. Same from 17-02-28 → 17-03-01.
- Year wrap: set 99-12-31 23:59:59, one tick → 00-01-01 00:00:00.
- 12 h display: stored 00:05 → H=12, PM=0. 12:00 → H=12, PM=1. 13:00 → H=01, PM=1. Toggle TIME_FORMAT → stored value unchanged.
- Invalid loads: SET_DATE 17-02-29 → SET_ERR pulse, date unchanged. SET_TIME hour 24 → SET_ERR, time unchanged.
- Collision/reset: SET_TIME on a tick edge → loaded value displayed, no increment. RESETN low mid-count → all fields return to reset values next cycle, prescaler restarts at 0.
